// File: rtl/factorial_ctrl.sv
// Sequencing controller that computes n! in an external 4x8 2R/1W register file.
// Optional build macro FACT_SATURATE_EN clamps the accumulator to 8'hFF on overflow.
module factorial_ctrl (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] n_in,
  output logic       busy,
  output logic       done,
  output logic [7:0] result,
  output logic       ovf,
  output logic [7:0] rf_data,
  output logic       rf_we,
  output logic [1:0] rf_wa,
  output logic       rf_rea,
  output logic       rf_reb,
  output logic [1:0] rf_raa,
  output logic [1:0] rf_rab,
  input  logic [7:0] rf_rda,
  input  logic [7:0] rf_rdb
);

  typedef enum logic [2:0] {
    IDLE,
    INIT_N,
    INIT_ACC,
    INIT_ONE,
    CHECK,
    MUL,
    DEC,
    DONE
  } state_e;

  localparam logic [1:0] REG_I   = 2'd0;
  localparam logic [1:0] REG_ACC = 2'd1;
  localparam logic [1:0] REG_ONE = 2'd2;

  state_e      state_q, state_d;
  logic [7:0]  nCapture_q, nCapture_d;
  logic        ovf_q, ovf_d;
  logic        done_q, done_d;
  logic [7:0]  result_q, result_d;

  logic [15:0] product;
  logic        productOvf;
  logic [7:0]  mulData;

  assign product    = {8'd0, rf_rda} * {8'd0, rf_rdb};
  assign productOvf = |product[15:8];

`ifdef FACT_SATURATE_EN
  // Once clamped, every later product with i >= 2 overflows again, so 8'hFF sticks.
  assign mulData = productOvf ? 8'hFF : product[7:0];
`else
  assign mulData = product[7:0];
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      nCapture_q <= 8'd0;
      ovf_q      <= 1'b0;
      done_q     <= 1'b0;
      result_q   <= 8'd0;
    end else begin
      state_q    <= state_d;
      nCapture_q <= nCapture_d;
      ovf_q      <= ovf_d;
      done_q     <= done_d;
      result_q   <= result_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    nCapture_d = nCapture_q;
    ovf_d      = ovf_q;
    done_d     = 1'b0;
    result_d   = result_q;
    rf_data    = 8'd0;
    rf_we      = 1'b0;
    rf_wa      = 2'd0;
    rf_rea     = 1'b0;
    rf_reb     = 1'b0;
    rf_raa     = 2'd0;
    rf_rab     = 2'd0;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          nCapture_d = n_in;
          ovf_d      = 1'b0;
          state_d    = INIT_N;
        end
      end
      INIT_N: begin
        rf_we   = 1'b1;
        rf_wa   = REG_I;
        rf_data = nCapture_q;
        state_d = INIT_ACC;
      end
      INIT_ACC: begin
        rf_we   = 1'b1;
        rf_wa   = REG_ACC;
        rf_data = 8'd1;
        state_d = INIT_ONE;
      end
      INIT_ONE: begin
        rf_we   = 1'b1;
        rf_wa   = REG_ONE;
        rf_data = 8'd1;
        state_d = CHECK;
      end
      CHECK: begin
        rf_rea  = 1'b1;
        rf_raa  = REG_I;
        state_d = (rf_rda <= 8'd1) ? DONE : MUL;
      end
      MUL: begin
        rf_rea  = 1'b1;
        rf_raa  = REG_I;
        rf_reb  = 1'b1;
        rf_rab  = REG_ACC;
        rf_we   = 1'b1;
        rf_wa   = REG_ACC;
        rf_data = mulData;
        if (productOvf) ovf_d = 1'b1;
        state_d = DEC;
      end
      DEC: begin
        rf_rea  = 1'b1;
        rf_raa  = REG_I;
        rf_reb  = 1'b1;
        rf_rab  = REG_ONE;
        rf_we   = 1'b1;
        rf_wa   = REG_I;
        rf_data = rf_rda - rf_rdb;
        state_d = CHECK;
      end
      DONE: begin
        rf_rea   = 1'b1;
        rf_raa   = REG_ACC;
        result_d = rf_rda;
        done_d   = 1'b1;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy   = (state_q != IDLE);
  assign done   = done_q;
  assign result = result_q;
  assign ovf    = ovf_q;

endmodule

// File: tb/tb_factorial_ctrl.sv
// Self-checking bench for factorial_ctrl paired with a behavioural 4x8 register file.
// Expected results come from a plain-arithmetic factorial model.
module tb_factorial_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] n_in;
  logic       busy, done, ovf;
  logic [7:0] result;
  logic [7:0] rf_data;
  logic       rf_we, rf_rea, rf_reb;
  logic [1:0] rf_wa, rf_raa, rf_rab;
  logic [7:0] rf_rda, rf_rdb;

  logic [7:0] rfMem [4];

  int checkCount = 0;
  int passCount  = 0;

`ifdef FACT_SATURATE_EN
  localparam int EXP6 = 255;
  localparam int EXP7 = 255;
`else
  localparam int EXP6 = 208;
  localparam int EXP7 = 176;
`endif

  factorial_ctrl dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .n_in   (n_in),
    .busy   (busy),
    .done   (done),
    .result (result),
    .ovf    (ovf),
    .rf_data(rf_data),
    .rf_we  (rf_we),
    .rf_wa  (rf_wa),
    .rf_rea (rf_rea),
    .rf_reb (rf_reb),
    .rf_raa (rf_raa),
    .rf_rab (rf_rab),
    .rf_rda (rf_rda),
    .rf_rdb (rf_rdb)
  );

  always #5 clk = ~clk;

  // Register file: combinational reads (pre-write value), write lands on the edge.
  always @(posedge clk) if (rf_we) rfMem[rf_wa] <= rf_data;
  assign rf_rda = rf_rea ? rfMem[rf_raa] : 8'h00;
  assign rf_rdb = rf_reb ? rfMem[rf_rab] : 8'h00;

  function automatic void refFact(input int n, output int res, output bit ov);
    int acc;
    int p;
    acc = 1;
    ov  = 1'b0;
    for (int i = n; i >= 2; i--) begin
      p = acc * i;
      if (p > 255) ov = 1'b1;
`ifdef FACT_SATURATE_EN
      acc = (p > 255) ? 255 : p;
`else
      acc = p % 256;
`endif
    end
    res = acc;
  endfunction

  function automatic int refLatency(input int n);
    return (n <= 1) ? 5 : 5 + 3 * (n - 1);
  endfunction

  function automatic int refWrites(input int n);
    return (n <= 1) ? 3 : 3 + 2 * (n - 1);
  endfunction

  // Pulses start, then waits for done; optionally re-pulses start at cycle pulseAt.
  task automatic run_fact(input logic [7:0] n, input int pulseAt,
                          output int lat, output int writes, output int busyLow);
    start = 1'b1;
    n_in  = n;
    @(posedge clk); #1;
    start   = 1'b0;
    n_in    = 8'($urandom);
    writes  = rf_we ? 1 : 0;
    busyLow = busy ? 0 : 1;
    lat     = 0;
    for (int k = 1; k <= 400; k++) begin
      if (k == pulseAt) begin
        start = 1'b1;
        n_in  = 8'd3;
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
      if (done) begin
        lat = k;
        break;
      end
      if (rf_we) writes++;
      if (!busy) busyLow++;
    end
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; n_in = 8'd0;
    repeat (2) @(posedge clk);
    #1;
    checkCount++;
    if ({busy, done, ovf} !== 3'b000)
      $display("[TB] FAIL reset_flags: got %b expected 000", {busy, done, ovf});
    else passCount++;
    checkCount++;
    if (result !== 8'd0) $display("[TB] FAIL reset_result: got %0d expected 0", result);
    else passCount++;
    checkCount++;
    if ({rf_we, rf_rea, rf_reb, rf_wa, rf_raa, rf_rab, rf_data} !== 17'd0)
      $display("[TB] FAIL reset_rf: got %h expected 0",
               {rf_we, rf_rea, rf_reb, rf_wa, rf_raa, rf_rab, rf_data});
    else passCount++;
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_n5();
    int lat, wr, bl;
    run_fact(8'd5, 0, lat, wr, bl);
    checkCount++;
    if (lat !== 17) $display("[TB] FAIL n5_latency: got %0d expected 17", lat);
    else passCount++;
    checkCount++;
    if (result !== 8'd120 || ovf !== 1'b0)
      $display("[TB] FAIL n5_result: got %0d/%b expected 120/0", result, ovf);
    else passCount++;
    checkCount++;
    if (busy !== 1'b0 || bl !== 0)
      $display("[TB] FAIL n5_busy: got busy=%b lowCycles=%0d expected 0/0", busy, bl);
    else passCount++;
    @(posedge clk); #1;
    checkCount++;
    if (done !== 1'b0 || result !== 8'd120)
      $display("[TB] FAIL n5_hold: got done=%b result=%0d expected 0/120", done, result);
    else passCount++;
  endtask

  task automatic test_small();
    int lat, wr, bl;
    for (int n = 0; n <= 1; n++) begin
      run_fact(8'(n), 0, lat, wr, bl);
      checkCount++;
      if (lat !== 5) $display("[TB] FAIL small%0d_latency: got %0d expected 5", n, lat);
      else passCount++;
      checkCount++;
      if (result !== 8'd1 || ovf !== 1'b0)
        $display("[TB] FAIL small%0d_result: got %0d/%b expected 1/0", n, result, ovf);
      else passCount++;
      checkCount++;
      if (wr !== 3) $display("[TB] FAIL small%0d_writes: got %0d expected 3", n, wr);
      else passCount++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_overflow();
    int lat, wr, bl;
    run_fact(8'd6, 0, lat, wr, bl);
    checkCount++;
    if (result !== 8'(EXP6) || ovf !== 1'b1)
      $display("[TB] FAIL n6_result: got %0d/%b expected %0d/1", result, ovf, EXP6);
    else passCount++;
    checkCount++;
    if (lat !== 20) $display("[TB] FAIL n6_latency: got %0d expected 20", lat);
    else passCount++;
    @(posedge clk); #1;
  endtask

  task automatic test_busy_ignore();
    int lat, wr, bl;
    run_fact(8'd7, 6, lat, wr, bl);
    checkCount++;
    if (result !== 8'(EXP7) || ovf !== 1'b1)
      $display("[TB] FAIL busy_ignore_result: got %0d/%b expected %0d/1", result, ovf, EXP7);
    else passCount++;
    checkCount++;
    if (lat !== 23) $display("[TB] FAIL busy_ignore_latency: got %0d expected 23", lat);
    else passCount++;
    @(posedge clk); #1;
    checkCount++;
    if (busy !== 1'b0) $display("[TB] FAIL busy_ignore_idle: got busy=%b expected 0", busy);
    else passCount++;
  endtask

  task automatic test_mid_reset();
    int lat, wr, bl;
    start = 1'b1;
    n_in  = 8'd5;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    checkCount++;
    if ({rf_rea, rf_reb, rf_we, rf_wa} !== 5'b111_01)
      $display("[TB] FAIL midreset_in_mul: got %b expected 11101", {rf_rea, rf_reb, rf_we, rf_wa});
    else passCount++;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checkCount++;
    if ({busy, done, ovf} !== 3'b000 || result !== 8'd0)
      $display("[TB] FAIL midreset_outputs: got %b/%0d expected 000/0", {busy, done, ovf}, result);
    else passCount++;
    checkCount++;
    if ({rf_we, rf_rea, rf_reb, rf_wa, rf_raa, rf_rab, rf_data} !== 17'd0)
      $display("[TB] FAIL midreset_rf: got %h expected 0",
               {rf_we, rf_rea, rf_reb, rf_wa, rf_raa, rf_rab, rf_data});
    else passCount++;
    run_fact(8'd4, 0, lat, wr, bl);
    checkCount++;
    if (result !== 8'd24 || ovf !== 1'b0 || lat !== 14)
      $display("[TB] FAIL midreset_rerun: got %0d/%b lat=%0d expected 24/0 lat=14", result, ovf, lat);
    else passCount++;
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    int lat, wr, bl;
    run_fact(8'd3, 0, lat, wr, bl);
    checkCount++;
    if (result !== 8'd6 || lat !== 11)
      $display("[TB] FAIL b2b_first: got %0d lat=%0d expected 6 lat=11", result, lat);
    else passCount++;
    run_fact(8'd4, 0, lat, wr, bl);
    checkCount++;
    if (result !== 8'd24 || ovf !== 1'b0 || lat !== 14)
      $display("[TB] FAIL b2b_second: got %0d/%b lat=%0d expected 24/0 lat=14", result, ovf, lat);
    else passCount++;
    @(posedge clk); #1;
  endtask

  task automatic test_random();
    int lat, wr, bl, n, expRes;
    bit expOvf;
    for (int t = 0; t < 10; t++) begin
      n = int'($urandom_range(0, 12));
      refFact(n, expRes, expOvf);
      run_fact(8'(n), 0, lat, wr, bl);
      checkCount++;
      if (result !== 8'(expRes) || ovf !== expOvf)
        $display("[TB] FAIL rand_n%0d_result: got %0d/%b expected %0d/%b", n, result, ovf, expRes, expOvf);
      else passCount++;
      checkCount++;
      if (lat !== refLatency(n) || wr !== refWrites(n))
        $display("[TB] FAIL rand_n%0d_timing: got lat=%0d wr=%0d expected lat=%0d wr=%0d",
                 n, lat, wr, refLatency(n), refWrites(n));
      else passCount++;
      repeat (int'($urandom_range(0, 2))) @(posedge clk);
      #1;
    end
  endtask

  initial begin
    test_reset();
    test_n5();
    test_small();
    test_overflow();
    test_busy_ignore();
    test_mid_reset();
    test_back_to_back();
    test_random();
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule

// File: doc/factorial_ctrl.md
# factorial_ctrl

Sequencing controller for the factorial datapath. It initiates every access to the 4×8 two-read/one-write register file: it drives the write port and both read-enable/read-address ports, and consumes the two read-data buses. It owns the 8×8 multiply and the decrement. A `start` pulse with operand `n_in` runs n! in the register file and returns the 8-bit result with an overflow flag.

## Interface
Parameters:
- None. Widths are fixed: 8-bit data, 2-bit register addresses.

Ports:
- Clocking and reset (one clock; reset is synchronous and active-high):
  - `clk`  in  1  rising-edge clock.
  - `rst`  in  1  synchronous active-high reset.
- Host side:
  - `start`  in  1  request. Sampled only in IDLE.
  - `n_in`  in  8  operand. Captured on the edge that accepts `start`.
  - `busy`  out  1  high in every state except IDLE.
  - `done`  out  1  registered one-cycle pulse when the result is valid.
  - `result`  out  8  final accumulator value. Held until the next `done`.
  - `ovf`  out  1  sticky. Set if any product exceeded 255. Cleared on accepted `start`.
- Register-file side:
  - `rf_data`  out  8  write data.
  - `rf_we`  out  1  write enable.
  - `rf_wa`  out  2  write address.
  - `rf_rea`, `rf_reb`  out  1 each  read enables. Deasserted when unused, so the buses float.
  - `rf_raa`, `rf_rab`  out  2 each  read addresses.
  - `rf_rda`, `rf_rdb`  in  8 each  combinational read data.

## Operation
Register map:
- R0 = counter i.
- R1 = accumulator.
- R2 = constant 1.
- R3 is never accessed.

States and transitions (Moore decode; all register-file controls are 0 unless listed):
- IDLE: when `start`=1, capture `n_in`, clear `ovf`, go to INIT_N.
- INIT_N: `rf_we`=1, `rf_wa`=0, `rf_data`=captured n. Go to INIT_ACC.
- INIT_ACC: write R1 = 1. Go to INIT_ONE.
- INIT_ONE: write R2 = 1. Go to CHECK.
- CHECK: `rf_rea`=1, `rf_raa`=0. If `rf_rda` ≤ 1, go to DONE; otherwise go to MUL.
- MUL:
  - Reads: A reads R0, B reads R1.
  - Product: p = `rf_rda` × `rf_rdb`, 16-bit.
  - Write: R1 = p[7:0].
  - If p[15:8] ≠ 0, set `ovf`.
  - Go to DEC.
- DEC:
  - Reads: A reads R0, B reads R2.
  - Write: R0 = `rf_rda` − `rf_rdb`, 8-bit.
  - Go to CHECK.
- DONE:
  - Read: A reads R1.
  - On the exit edge: `result` ← `rf_rda`, `done` ← 1.
  - Go to IDLE.

Rules:
- A read and a write in the same cycle is legal. The read returns the pre-write value; the write lands on the edge.
- `start` is ignored while `busy`=1.
- `n_in` changes after acceptance have no effect.
- n = 0 and n = 1 both yield 1 and never enter MUL.

Reset:
- `rst` forces IDLE from any state. This includes mid-computation.
- Reset values: `busy`=0, `done`=0, `result`=0, `ovf`=0, `rf_we`=0, `rf_rea`=0, `rf_reb`=0, `rf_wa`=`rf_raa`=`rf_rab`=0, `rf_data`=0.
- Register-file contents are not cleared. The next run reinitialises R0–R2.

## Timing
- Let edge 0 be the edge that accepts `start`.
- `busy` rises after edge 0 and falls with the edge that raises `done`.
- Latency:
  - n ≤ 1: `done` is high in the cycle after edge 5.
  - n ≥ 2: `done` is high after edge 5 + 3·(n−1). For n=5 that is edge 17.
- `done` lasts exactly one cycle.
- A new `start` is accepted in the same cycle `done` is high, because the state is IDLE.
- `result` and `ovf` update on the `done` edge. `ovf` may additionally rise during MUL.
- Combinational paths: `rf_data` depends on `rf_rda`/`rf_rdb` in MUL and DEC. This path plus the multiplier must close in one cycle.

## Configuration
`FACT_SATURATE_EN`:
- Defined: in MUL, when p > 255, R1 is written 8'hFF instead of p[7:0]. Once R1 is 8'hFF, every later product also exceeds 255 because i ≥ 2, so the final result stays 8'hFF.
- Undefined: R1 = p[7:0], i.e. modulo-256 truncation.
- `ovf` behaves identically in both builds.

## Test plan
Bench pairs the block with a behavioural 4×8 register-file model.
- n=5: `start` pulse → `done` after edge 17, `result`=120, `ovf`=0.
- n=0 and n=1 → `done` after edge 5, `result`=1, `ovf`=0, `rf_we` never asserted in a MUL state.
- n=6:
  - Default build → `result`=208 (720 mod 256), `ovf`=1.
  - With `FACT_SATURATE_EN` → `result`=255, `ovf`=1.
- Start n=7, then pulse `start` with n=3 while `busy`:
  - The second request is ignored.
  - `result` = 5040 mod 256 = 176 (255 with the macro), `ovf`=1.
- Assert `rst` for one cycle during the third MUL of n=5:
  - All outputs read their reset values on the next cycle and `busy`=0.
  - A following n=4 run gives `result`=24, `ovf`=0.
- Back-to-back: start n=3, then re-`start` with n=4 in the `done` cycle:
  - First run: `result`=6 after edge 11.
  - Second run: `result`=24 after edge 14 relative to its acceptance.
